// File: rtl/div_unit.sv
// Iterative 32/32 divider for the EX stage: signed (DIV) and unsigned (DIVU)
// using 32 restoring shift-subtract steps, with divide-by-zero and annul paths.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  localparam int unsigned DW  = 32;
  localparam int unsigned PW  = 2 * DW + 1;
  localparam int unsigned CW  = 6;
  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   partial_q, partial_d;
  logic [DW-1:0]   divisor_q, divisor_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  logic [2*DW-1:0] result_d;
  logic            ready_d;

  // Operand magnitudes; two's-complement negation maps 0x80000000 to itself
  logic [DW-1:0]   abs1, abs2;
  // One restoring step on {remainder[32:0], quotient[31:0]}
  logic [DW:0]     shifted, diff;
  logic            ge;
  logic [PW-1:0]   step;
  logic [DW-1:0]   q_mag, r_mag, q_fin, r_fin;

  // Datapath for a single shift-subtract step and final sign correction
  always_comb begin
    abs1    = (signed_div_i && opdata1_i[DW-1]) ? DW'(-opdata1_i) : opdata1_i;
    abs2    = (signed_div_i && opdata2_i[DW-1]) ? DW'(-opdata2_i) : opdata2_i;
    shifted = {partial_q[2*DW-1:DW], partial_q[DW-1]};
    ge      = shifted >= {1'b0, divisor_q};
    diff    = shifted - {1'b0, divisor_q};
    step    = ge ? {diff, partial_q[DW-2:0], 1'b1}
                 : {shifted, partial_q[DW-2:0], 1'b0};
    q_mag   = step[DW-1:0];
    r_mag   = step[2*DW-1:DW];
    q_fin   = neg_q_q ? DW'(-q_mag) : q_mag;
    r_fin   = neg_r_q ? DW'(-r_mag) : r_mag;
  end

  // Next-state, datapath loads, stall request
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    partial_d  = partial_q;
    divisor_d  = divisor_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    result_d   = '0;
    ready_d    = 1'b0;
    stallreq_o = 1'b0;
    case (state_q)
      ST_FREE: begin
        if (start_i && !annul_i) begin
          stallreq_o = 1'b1;
          partial_d  = {(DW + 1)'(0), abs1};
          divisor_d  = abs2;
          neg_q_d    = signed_div_i && (opdata1_i[DW-1] ^ opdata2_i[DW-1]);
          neg_r_d    = signed_div_i && opdata1_i[DW-1];
          cnt_d      = '0;
          state_d    = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
        end
      end
      ST_BYZERO: begin
        if (annul_i) begin
          state_d = ST_FREE;
        end else begin
          stallreq_o = 1'b1;
          state_d    = ST_END;
          ready_d    = 1'b1;
        end
      end
      ST_ON: begin
        if (annul_i) begin
          state_d = ST_FREE;
        end else begin
          stallreq_o = 1'b1;
          partial_d  = step;
          cnt_d      = cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            state_d  = ST_END;
            ready_d  = 1'b1;
            result_d = {r_fin, q_fin};
          end
        end
      end
      ST_END: begin
        if (annul_i || !start_i) begin
          state_d = ST_FREE;
        end else begin
          ready_d  = 1'b1;
          result_d = result_o;
        end
      end
      default: state_d = ST_FREE;
    endcase
    if (rst) stallreq_o = 1'b0;
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FREE;
      cnt_q     <= '0;
      partial_q <= '0;
      divisor_q <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      partial_q <= partial_d;
      divisor_q <= divisor_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      result_o  <= result_d;
      ready_o   <= ready_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random
// divides compared against a plain-arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int total = 0;
  int bad   = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {remainder, quotient} from plain 64-bit arithmetic
  function automatic logic [63:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Advance to just after the next edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide, follow it through, hold start for 'hold' extra cycles
  task automatic run_op(input bit sg, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [63:0] exp;
    int exp_lat, cyc;
    bit got;
    exp     = model(sg, a, b);
    exp_lat = (b == 32'd0) ? 2 : 33;
    start_i = 1'b1; signed_div_i = sg; opdata1_i = a; opdata2_i = b; annul_i = 1'b0;
    #1;
    check("stall_accept", 64'(stallreq_o), 64'd1);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      tick();
      cyc++;
      opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'($urandom);
      #1;
      if (ready_o) got = 1'b1;
      else begin
        check("stall_busy", 64'(stallreq_o), 64'd1);
        check("result_busy", result_o, 64'd0);
      end
    end
    check("latency", 64'(cyc), 64'(exp_lat));
    check("result", result_o, exp);
    check("stall_end", 64'(stallreq_o), 64'd0);
    for (int i = 0; i < hold; i++) begin
      tick(); #1;
      check("hold_ready", 64'(ready_o), 64'd1);
      check("hold_result", result_o, exp);
    end
    start_i = 1'b0;
    tick(); #1;
    check("free_ready", 64'(ready_o), 64'd0);
    check("free_result", result_o, 64'd0);
    check("free_stall", 64'(stallreq_o), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    bit seen;
    rst = 1'b1; start_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0; annul_i = 1'b0;
    tick(); tick();
    start_i = 1'b1; opdata2_i = 32'd3;
    #1;
    check("rst_stall", 64'(stallreq_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    start_i = 1'b0;
    rst = 1'b0;
    tick();

    // Directed corners
    run_op(1'b0, 32'd100, 32'd7, 0);
    check("divu_100_7", model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b0, 32'd5, 32'd0, 0);
    run_op(1'b1, 32'h8000_0000, 32'd0, 1);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 3);

    // Annul in the middle of an operation
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    for (int i = 0; i < 10; i++) tick();
    annul_i = 1'b1; start_i = 1'b0;
    #1;
    check("annul_stall", 64'(stallreq_o), 64'd0);
    tick();
    annul_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (ready_o || result_o != 64'd0 || stallreq_o) seen = 1'b1;
      tick();
    end
    check("annul_quiet", 64'(seen), 64'd0);
    run_op(1'b0, 32'd9, 32'd3, 0);

    // Reset in the middle of an operation
    start_i = 1'b1; signed_div_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd9;
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    #1;
    check("rst_mid_stall", 64'(stallreq_o), 64'd0);
    tick();
    start_i = 1'b0;
    #1;
    check("rst_mid_ready", 64'(ready_o), 64'd0);
    check("rst_mid_result", result_o, 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready_o) seen = 1'b1;
    end
    check("rst_no_ready", 64'(seen), 64'd0);
    run_op(1'b0, 32'd9, 32'd3, 0);

    // Random operations
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(1'($urandom), a, b, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset; no other clock or reset SHALL exist.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start_i  input  1  EX requests a divide; held high until ready_o is seen.
REQ-006 signed_div_i  input  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled on start acceptance.
REQ-007 opdata1_i  input  32  dividend (rs); sampled on start acceptance.
REQ-008 opdata2_i  input  32  divisor (rt); sampled on start acceptance.
REQ-009 annul_i  input  1  abort of the current operation (pipeline flush).
REQ-010 result_o  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-011 ready_o  output  1  result_o valid this cycle.
REQ-012 stallreq_o  output  1  stall request to the stall controller, freezing IF/ID/EX while a divide is in flight.

Function
REQ-013 States: FREE, BYZERO, ON, END, held in a registered state plus a 6-bit cycle counter.
REQ-014 FREE: start_i=1 and annul_i=0 accepts the operands; divisor==0 -> BYZERO, else -> ON with counter=0.
REQ-015 FREE with start_i=0 or annul_i=1: remain in FREE; result_o=0, ready_o=0.
REQ-016 Signed mode: latch |dividend| and |divisor| as unsigned magnitudes, plus sign flags; 0x80000000 SHALL be handled as magnitude 0x80000000.
REQ-017 ON: perform one restoring shift-subtract step per cycle on a 65-bit partial remainder; counter increments each cycle.
REQ-018 ON SHALL last exactly 32 cycles, then go to END.
REQ-019 BYZERO SHALL last one cycle, then go to END with quotient=0 and remainder=0.
REQ-020 END: result_o valid and ready_o=1.
- Signed correction: quotient negated if dividend and divisor signs differ; remainder takes the dividend's sign.
REQ-021 END -> FREE when start_i=0; while start_i stays 1, remain in END with ready_o=1 and result_o held.
REQ-022 Latency: ready_o first asserts 33 cycles after acceptance (non-zero divisor) and 2 cycles after acceptance (zero divisor).
REQ-023 stallreq_o SHALL be high:
- in FREE when start_i=1 and annul_i=0;
- throughout BYZERO and ON.
REQ-024 stallreq_o SHALL be low in END and in FREE otherwise.
REQ-025 annul_i=1 in ON or BYZERO: go to FREE next cycle; ready_o never asserts for that operation; stallreq_o drops the same cycle.
REQ-026 annul_i in END: go to FREE next cycle.
REQ-027 Operand changes on opdata1_i, opdata2_i or signed_div_i after acceptance SHALL NOT affect the in-flight result.
REQ-028 result_o and ready_o SHALL be zero in every state except END.

Reset
REQ-029 rst=1 at a clock edge forces state=FREE, counter=0, result_o=0, ready_o=0, and clears all operand and partial-remainder registers, regardless of the current state.
REQ-030 While rst=1, stallreq_o=0; after rst deasserts, a new start is accepted on the first edge.

Verification
REQ-031 DIVU, 100 / 7, start held -> ready_o at cycle 33; result_o={32'd2, 32'd14}; stallreq_o high in cycles 0-32.
REQ-032 DIV, -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-033 DIVU, 5 / 0 -> BYZERO for one cycle, ready_o at cycle 2, result_o=0; stallreq_o low from cycle 2.
REQ-034 Start 100/7, annul_i pulse at cycle 10 -> FREE at cycle 11; ready_o stays 0; a following start 9/3 yields {0, 3} 33 cycles after its acceptance.
REQ-035 Start, then rst at cycle 20 -> all outputs 0 on the next cycle; no ready_o pulse from the aborted operation.
REQ-036 Hold start_i 3 cycles past ready_o -> result_o held stable, no re-start; start_i low -> FREE on the next cycle.
